// File: rtl/apb4_master_arbiter_if.sv
// Bundle of requester-side command/response signals and the APB4 master bus.
// master modport: the arbiter's view (takes commands, drives APB).
// slave modport : the environment's view (issues commands, answers APB).
//   req_valid/req_write/req_addr/req_wdata/req_strb/req_prot : flattened commands
//   req_accept/rsp_valid/rsp_rdata/rsp_err                   : handshake/response
//   PSEL..PSTRB / PRDATA,PREADY,PSLVERR                      : APB4 bus
interface apb4_master_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_REQ      = 2
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_write;
    logic [N_REQ*ADDR_WIDTH-1:0]   req_addr;
    logic [N_REQ*DATA_WIDTH-1:0]   req_wdata;
    logic [N_REQ*DATA_WIDTH/8-1:0] req_strb;
    logic [N_REQ*3-1:0]            req_prot;
    logic [N_REQ-1:0]              req_accept;
    logic [N_REQ-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic                          PSEL;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [2:0]                    PPROT;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH/8-1:0]       PSTRB;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output req_accept, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  req_accept, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_master_arbiter.sv
// Round-robin arbiter sharing one APB4 master port among N_REQ requesters.
// Each granted command runs SETUP then ACCESS; the response is returned to the
// requester that issued it. Optional PREADY timeout (TIMEOUT > 0) aborts a hung
// transfer with an error response.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : apb4_master_arbiter_if.master (requester commands/responses + APB4)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | bus idle (PSEL=0); arbitrate every cycle
// S_SETUP  | APB setup phase (PSEL=1, PENABLE=0), always one cycle
// S_ACCESS | APB access phase (PSEL=1, PENABLE=1); arbitrate on PREADY
module apb4_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_REQ      = 2,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    apb4_master_arbiter_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_owner;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [2:0]            r_pprot;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic [N_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [N_REQ];
    logic [STRB_W-1:0]     w_strb_arr  [N_REQ];
    logic [2:0]            w_prot_arr  [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb_arr[gi]  = bus.req_strb[gi*STRB_W +: STRB_W];
        assign w_prot_arr[gi]  = bus.req_prot[gi*3 +: 3];
    end

    // Rotate the valid vector so bit 0 is the requester at the pointer; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    logic [2*N_REQ-1:0] w_shift;
    logic [N_REQ-1:0]   w_rot;
    logic               w_gnt_any;
    int                 w_first;
    int                 w_sum;
    int                 w_nxt;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;

    always_comb begin
        w_shift   = {bus.req_valid, bus.req_valid} >> r_ptr;
        w_rot     = w_shift[N_REQ-1:0];
        w_gnt_any = |w_rot;
        w_first   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_first = k;
        end
        w_sum = int'(r_ptr) + w_first;
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        w_nxt = w_sum + 1;
        if (w_nxt >= N_REQ) w_nxt = 0;
        w_gnt_idx = PTR_W'(w_sum);
        w_ptr_nxt = PTR_W'(w_nxt);
    end

    logic w_arb_slot;
    logic w_grant;
    logic w_timeout;

    assign w_arb_slot = (r_state == S_IDLE) || ((r_state == S_ACCESS) && bus.PREADY);
    assign w_grant    = w_arb_slot && w_gnt_any && !rst;
    // PREADY has priority: the limit only aborts when the slave is still stalling.
    assign w_timeout  = (TIMEOUT > 0) && (r_state == S_ACCESS) && !bus.PREADY &&
                        (r_to_cnt == TO_W'(TIMEOUT - 1));

    assign bus.req_accept = w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_to_cnt    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pprot     <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_gnt_idx;
                        r_ptr     <= w_ptr_nxt;
                        r_pwrite  <= bus.req_write[w_gnt_idx];
                        r_paddr   <= w_addr_arr[w_gnt_idx];
                        r_pwdata  <= w_wdata_arr[w_gnt_idx];
                        r_pstrb   <= bus.req_write[w_gnt_idx] ? w_strb_arr[w_gnt_idx] : '0;
                        r_pprot   <= w_prot_arr[w_gnt_idx];
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_to_cnt  <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_rdata          <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err            <= bus.PSLVERR;
                        r_penable            <= 1'b0;
                        if (w_grant) begin
                            // Back-to-back: PSEL stays high straight into SETUP.
                            r_owner  <= w_gnt_idx;
                            r_ptr    <= w_ptr_nxt;
                            r_pwrite <= bus.req_write[w_gnt_idx];
                            r_paddr  <= w_addr_arr[w_gnt_idx];
                            r_pwdata <= w_wdata_arr[w_gnt_idx];
                            r_pstrb  <= bus.req_write[w_gnt_idx] ? w_strb_arr[w_gnt_idx] : '0;
                            r_pprot  <= w_prot_arr[w_gnt_idx];
                            r_psel   <= 1'b1;
                            r_state  <= S_SETUP;
                        end else begin
                            r_psel  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_rdata          <= '0;
                        r_rsp_err            <= 1'b1;
                        r_psel               <= 1'b0;
                        r_penable            <= 1'b0;
                        r_state              <= S_IDLE;
                    end else if (TIMEOUT > 0) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PPROT     = r_pprot;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.PSTRB     = r_pstrb;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Directed bench for apb4_master_arbiter (N_REQ=2, 32-bit, TIMEOUT=4).
// Inputs are driven on the falling edge; outputs are checked 1 ns later.
module tb_apb4_master_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    apb4_master_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_REQ(2)) bus ();

    apb4_master_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .N_REQ(2), .TIMEOUT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        if (i == 0) begin
            bus.req_valid[0]     = v;
            bus.req_write[0]     = w;
            bus.req_addr[31:0]   = a;
            bus.req_wdata[31:0]  = d;
            bus.req_strb[3:0]    = s;
            bus.req_prot[2:0]    = p;
        end else begin
            bus.req_valid[1]     = v;
            bus.req_write[1]     = w;
            bus.req_addr[63:32]  = a;
            bus.req_wdata[63:32] = d;
            bus.req_strb[7:4]    = s;
            bus.req_prot[5:3]    = p;
        end
    endtask

    task automatic slave(input logic rdy, input logic [31:0] rd, input logic err);
        bus.PREADY  = rdy;
        bus.PRDATA  = rd;
        bus.PSLVERR = err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        slave(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] addr_of [2];
    logic [63:0] e;
    int          g;

    initial begin
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'h2);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        slave(1'b1, 32'h0, 1'b0);

        // Reset state: everything zero even with a valid request present.
        @(negedge clk); #1;
        chk("rst accept", 64'(bus.req_accept), 64'h0);
        chk("rst psel", 64'(bus.PSEL), 64'h0);
        chk("rst penable", 64'(bus.PENABLE), 64'h0);
        chk("rst rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst paddr", 64'(bus.PADDR), 64'h0);
        do_reset();

        // 1: single write from requester 0, zero wait states.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'h2);
        slave(1'b1, 32'h77, 1'b0);
        #1;
        chk("w1 accept", 64'(bus.req_accept), 64'h1);
        chk("w1 idle psel", 64'(bus.PSEL), 64'h0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        #1;
        chk("w1 setup psel", 64'(bus.PSEL), 64'h1);
        chk("w1 setup penable", 64'(bus.PENABLE), 64'h0);
        chk("w1 paddr", 64'(bus.PADDR), 64'h10);
        chk("w1 pwdata", 64'(bus.PWDATA), 64'hA5A5A5A5);
        chk("w1 pstrb", 64'(bus.PSTRB), 64'hF);
        chk("w1 pwrite", 64'(bus.PWRITE), 64'h1);
        chk("w1 pprot", 64'(bus.PPROT), 64'h2);
        chk("w1 setup accept", 64'(bus.req_accept), 64'h0);
        @(negedge clk); #1;
        chk("w1 access psel", 64'(bus.PSEL), 64'h1);
        chk("w1 access penable", 64'(bus.PENABLE), 64'h1);
        chk("w1 access rsp", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk); #1;
        chk("w1 rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("w1 rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("w1 rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
        chk("w1 psel off", 64'(bus.PSEL), 64'h0);
        @(negedge clk); #1;
        chk("w1 rsp pulse", 64'(bus.rsp_valid), 64'h0);

        // 2: both requesters read back-to-back; grants alternate 0,1,0,1.
        do_reset();
        addr_of[0] = 32'h20;
        addr_of[1] = 32'h24;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 3'h0);
        set_req(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 3'h0);
        slave(1'b1, 32'h11, 1'b0);
        #1;
        for (int t = 0; t < 4; t++) begin
            g = t % 2;
            e = 64'd1 << g;
            chk("rr accept", 64'(bus.req_accept), e);
            if (t > 0) begin
                chk("rr access psel", 64'(bus.PSEL), 64'h1);
                chk("rr access penable", 64'(bus.PENABLE), 64'h1);
            end else begin
                chk("rr idle psel", 64'(bus.PSEL), 64'h0);
            end
            @(negedge clk);
            if (t == 3) begin
                set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
                set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
            end
            #1;
            chk("rr setup psel", 64'(bus.PSEL), 64'h1);
            chk("rr setup penable", 64'(bus.PENABLE), 64'h0);
            chk("rr paddr", 64'(bus.PADDR), 64'(addr_of[g]));
            chk("rr pstrb", 64'(bus.PSTRB), 64'h0);
            if (t > 0) begin
                e = 64'd1 << (1 - g);
                chk("rr rsp_valid", 64'(bus.rsp_valid), e);
                chk("rr rsp_rdata", 64'(bus.rsp_rdata), 64'h11);
            end
            @(negedge clk); #1;
        end
        chk("rr last accept", 64'(bus.req_accept), 64'h0);
        chk("rr last penable", 64'(bus.PENABLE), 64'h1);
        @(negedge clk); #1;
        chk("rr last rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("rr last rsp_rdata", 64'(bus.rsp_rdata), 64'h11);
        chk("rr end psel", 64'(bus.PSEL), 64'h0);

        // 3: read with 3 wait states, then data with slave error.
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 3'h0);
        slave(1'b0, 32'h0, 1'b0);
        #1;
        chk("ws accept", 64'(bus.req_accept), 64'h2);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        #1;
        chk("ws setup paddr", 64'(bus.PADDR), 64'h30);
        chk("ws setup pstrb", 64'(bus.PSTRB), 64'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) slave(1'b1, 32'hDEADBEEF, 1'b1);
            #1;
            chk("ws paddr", 64'(bus.PADDR), 64'h30);
            chk("ws penable", 64'(bus.PENABLE), 64'h1);
            chk("ws pstrb", 64'(bus.PSTRB), 64'h0);
            chk("ws rsp idle", 64'(bus.rsp_valid), 64'h0);
        end
        @(negedge clk);
        slave(1'b0, 32'h0, 1'b0);
        #1;
        chk("ws rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("ws rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("ws rsp_err", 64'(bus.rsp_err), 64'h1);
        chk("ws psel off", 64'(bus.PSEL), 64'h0);

        // 4: PREADY stuck low -> timeout after 4 ACCESS cycles, then serve req 1.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 3'h0);
        set_req(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 3'h0);
        #1;
        chk("to accept", 64'(bus.req_accept), 64'h1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        #1;
        chk("to setup paddr", 64'(bus.PADDR), 64'h40);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("to access psel", 64'(bus.PSEL), 64'h1);
            chk("to access accept", 64'(bus.req_accept), 64'h0);
        end
        @(negedge clk);
        slave(1'b1, 32'h55, 1'b0);
        #1;
        chk("to psel drop", 64'(bus.PSEL), 64'h0);
        chk("to penable drop", 64'(bus.PENABLE), 64'h0);
        chk("to rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("to rsp_err", 64'(bus.rsp_err), 64'h1);
        chk("to rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
        chk("to next accept", 64'(bus.req_accept), 64'h2);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        #1;
        chk("to next paddr", 64'(bus.PADDR), 64'h44);
        chk("to next rsp idle", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk); #1;
        chk("to next penable", 64'(bus.PENABLE), 64'h1);
        @(negedge clk); #1;
        chk("to next rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("to next rsp_rdata", 64'(bus.rsp_rdata), 64'h55);
        chk("to next rsp_err", 64'(bus.rsp_err), 64'h0);

        // 5: PREADY rises in the cycle the limit would be hit -> normal completion.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 3'h0);
        slave(1'b0, 32'h0, 1'b0);
        #1;
        chk("lim accept", 64'(bus.req_accept), 64'h1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) slave(1'b1, 32'h99, 1'b0);
            #1;
            chk("lim access psel", 64'(bus.PSEL), 64'h1);
        end
        @(negedge clk);
        slave(1'b0, 32'h0, 1'b0);
        #1;
        chk("lim rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("lim rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("lim rsp_rdata", 64'(bus.rsp_rdata), 64'h0);

        // 6: reset in the middle of ACCESS, then pointer restarts at 0.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h60, 32'h1, 4'hF, 3'h0);
        #1;
        chk("rm accept", 64'(bus.req_accept), 64'h1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        @(negedge clk); #1;
        chk("rm access penable", 64'(bus.PENABLE), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("rm psel drop", 64'(bus.PSEL), 64'h0);
        chk("rm penable drop", 64'(bus.PENABLE), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        slave(1'b1, 32'h0, 1'b0);
        #1;
        chk("rm no rsp", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'h70, 32'h0, 4'h0, 3'h0);
        set_req(1, 1'b1, 1'b0, 32'h74, 32'h0, 4'h0, 3'h0);
        #1;
        chk("rm no rsp later", 64'(bus.rsp_valid), 64'h0);
        chk("rm first grant", 64'(bus.req_accept), 64'h1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        #1;
        chk("rm paddr", 64'(bus.PADDR), 64'h70);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rm rsp_valid", 64'(bus.rsp_valid), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb4_master_arbiter.md
Name: apb4_master_arbiter

Overview:
- Shares one APB4 master port between N_REQ independent requesters using round-robin arbitration.
- Sequences each granted command through the APB4 SETUP and ACCESS phases, then returns the response to the requester that issued it.
- Includes an optional PREADY timeout that aborts a hung transfer and reports an error.
- Sits between on-chip bus initiators (test harness drivers, DMA, debug) and a single APB4 slave such as a generated register block.

Parameters:
- DATA_WIDTH, 32, APB data width; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 32, APB address width.
- N_REQ, 2, number of requesters, 2..8.
- TIMEOUT, 0, maximum ACCESS cycles to wait for PREADY; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester command valid.
- req_write  in  N_REQ  per-requester 1 = write.
- req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N_REQ*DATA_WIDTH  flattened write data.
- req_strb  in  N_REQ*DATA_WIDTH/8  flattened write strobes.
- req_prot  in  N_REQ*3  flattened PPROT values.
- req_accept  out  N_REQ  one-hot pulse: command captured this cycle.
- rsp_valid  out  N_REQ  one-hot pulse: response available.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB4 master controls.
- PPROT  out  3  APB4 protection.
- PADDR  out  ADDR_WIDTH  APB4 address.
- PWDATA  out  DATA_WIDTH  APB4 write data.
- PSTRB  out  DATA_WIDTH/8  APB4 write strobes.
- PRDATA  in  DATA_WIDTH  APB4 read data.
- PREADY, PSLVERR  in  1  APB4 ready and slave error.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, round-robin pointer = 0, timeout counter = 0.
  - All outputs are 0.
  - Reset during SETUP or ACCESS drops PSEL immediately; no rsp_valid is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration occurs in IDLE, or in ACCESS in the cycle PREADY = 1:
  - Grant g = first requester with req_valid = 1, searching from the pointer upward with wrap-around.
  - req_accept[g] is asserted combinationally in the grant cycle.
  - The command is registered onto the P* outputs; pointer becomes (g+1) mod N_REQ; next state = SETUP.
  - No valid request: remain in or return to IDLE with PSEL = 0, PENABLE = 0.
- Requester rules:
  - Requester holds its command stable while req_valid = 1 and req_accept = 0.
  - After accept, it either deasserts req_valid or presents its next command.
- SETUP: PSEL = 1, PENABLE = 0; always exactly one cycle, then ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1; wait states are held while PREADY = 0.
  - PREADY = 1: capture PRDATA, or 0 for writes.
  - rsp_err = PSLVERR.
  - rsp_valid[owner] pulses for one cycle starting the next cycle.
- Back-to-back transfers:
  - If a request is pending at PREADY, go directly ACCESS -> SETUP with PSEL held at 1.
  - Sustained throughput is one transfer per 2 cycles with zero wait states.
- Outputs:
  - PSTRB is forced to 0 for reads.
  - PADDR, PWDATA, PWRITE and PPROT stay stable from SETUP through the end of ACCESS.
  - All P* outputs are registered.
- Timeout (TIMEOUT > 0):
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - Reaching TIMEOUT aborts the transfer: PSEL = 0 and PENABLE = 0 next cycle; rsp_valid[owner] = 1, rsp_err = 1, rsp_rdata = 0.
  - Next state after abort is IDLE; no arbitration in the abort cycle.
  - Counter is ceil(log2(TIMEOUT+1)) bits.
  - If PREADY = 1 in the same cycle the limit is reached, PREADY wins and the transfer completes normally.
- Single-requester fairness: a requester that keeps req_valid high is still granted; the pointer rotation favours the other requesters whenever they are requesting.
- Latency: req_valid to PSEL is 1 cycle. PREADY to rsp_valid is 1 cycle.

Test Plan:
- Requester 0 writes addr 0x10, data 0xA5A5A5A5, strb 0xF, PREADY tied 1 -> accept in cycle 0; SETUP in cycle 1; ACCESS in cycle 2; rsp_valid[0] with err = 0 in cycle 3; PSTRB = 0xF.
- Requesters 0 and 1 both hold req_valid for 4 transfers, each slave read returning 0x11 -> grants alternate 0,1,0,1; PSEL stays high across transfers, no idle cycles; each rsp_rdata = 0x11 goes to the correct owner.
- Read with PREADY low for 3 ACCESS cycles, then high with PRDATA = 0xDEADBEEF and PSLVERR = 1 -> PADDR stable for 4 ACCESS cycles; rsp_rdata = 0xDEADBEEF, rsp_err = 1; PSTRB = 0 throughout.
- TIMEOUT = 4, PREADY stuck at 0 -> PSEL drops after 4 ACCESS cycles; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; the next pending request is then served normally.
- TIMEOUT = 4, PREADY rises in the 4th wait cycle -> normal completion with rsp_err = PSLVERR, no abort.
- rst asserted mid-ACCESS -> PSEL = 0 and PENABLE = 0 immediately, no rsp_valid; after release, the first grant goes to requester 0.
